// File: rtl/interpolation_line_reader.sv
// Read side of the interpolation line buffer: walks a stored source line at a
// fixed-point step and presents neighbour pixel pairs plus a fractional weight.
module interpolation_line_reader #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                           rd_clk,
   input  logic                           rd_rst,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          src_len,
   input  logic [ADDR_WIDTH-1:0]          dst_len,
   input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
   output logic                           busy,
   output logic                           done,
   output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
   input  logic [DATA_WIDTH-1:0]          ram_rd_data,
   output logic [DATA_WIDTH-1:0]          pix0,
   output logic [DATA_WIDTH-1:0]          pix1,
   output logic [FRAC_WIDTH-1:0]          frac,
   output logic                           out_valid,
   input  logic                           out_ready
);

   localparam int POS_W = ADDR_WIDTH + FRAC_WIDTH + 1;
   localparam int IDX_W = ADDR_WIDTH + 2;

   typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, WAIT, PRESENT} state_t;

   state_t                          state;
   logic [ADDR_WIDTH-1:0]           src_q;
   logic [ADDR_WIDTH-1:0]           dst_q;
   logic [ADDR_WIDTH-1:0]           count;
   logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step_q;
   logic [POS_W-1:0]                pos;
   logic [POS_W-1:0]                pos_next;
   logic [POS_W:0]                  pos_sum;
   logic [IDX_W-1:0]                idx_cur;
   logic [IDX_W-1:0]                idx_next;
   logic [IDX_W-1:0]                last_idx;
   // Each entry is {word_valid, is_second_word}, aligned with ram_rd_data at the tail.
   logic [1:0]                      tag_pipe [RD_LATENCY];

   function automatic logic [ADDR_WIDTH-1:0] clamp_idx(input logic [IDX_W-1:0] idx,
                                                       input logic [IDX_W-1:0] last);
      return (idx > last) ? last[ADDR_WIDTH-1:0] : idx[ADDR_WIDTH-1:0];
   endfunction

   // Saturating position advance and the integer indices derived from it.
   always_comb begin
      pos_sum  = {1'b0, pos} + {2'b00, step_q};
      pos_next = pos_sum[POS_W] ? '1 : pos_sum[POS_W-1:0];
      idx_cur  = {1'b0, pos[POS_W-1:FRAC_WIDTH]};
      idx_next = {1'b0, pos_next[POS_W-1:FRAC_WIDTH]};
      last_idx = {2'b00, src_q} - IDX_W'(1);
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_rd_addr <= '0;
         pix0        <= '0;
         pix1        <= '0;
         frac        <= '0;
         out_valid   <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         step_q      <= '0;
         pos         <= '0;
         count       <= '0;
         for (int k = 0; k < RD_LATENCY; k++) tag_pipe[k] <= 2'b00;
      end else begin
         done        <= 1'b0;
         tag_pipe[0] <= {(state == ADDR0) || (state == ADDR1), state == ADDR1};
         for (int k = 1; k < RD_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];

         if (tag_pipe[RD_LATENCY-1][1]) begin
            if (tag_pipe[RD_LATENCY-1][0]) pix1 <= ram_rd_data;
            else                           pix0 <= ram_rd_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  src_q  <= src_len;
                  dst_q  <= dst_len;
                  step_q <= step;
                  pos    <= '0;
                  count  <= '0;
                  // Empty passes finish immediately without touching the RAM.
                  if ((src_len == '0) || (dst_len == '0)) begin
                     done <= 1'b1;
                  end else begin
                     busy        <= 1'b1;
                     ram_rd_addr <= '0;
                     state       <= ADDR0;
                  end
               end
            end
            ADDR0: begin
               ram_rd_addr <= clamp_idx(idx_cur + IDX_W'(1), last_idx);
               state       <= ADDR1;
            end
            ADDR1: state <= WAIT;
            WAIT: begin
               if (tag_pipe[RD_LATENCY-1] == 2'b11) begin
                  frac      <= pos[FRAC_WIDTH-1:0];
                  out_valid <= 1'b1;
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  pos       <= pos_next;
                  count     <= count + ADDR_WIDTH'(1);
                  if (count == dst_q - ADDR_WIDTH'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     ram_rd_addr <= clamp_idx(idx_next, last_idx);
                     state       <= ADDR0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interpolation_line_reader.sv
// Scoreboard bench for interpolation_line_reader: one instance per RAM latency,
// expected pixel pairs come from an independent position model.
module tb_interpolation_line_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] src_len = '0;
   logic [10:0] dst_len = '0;
   logic [18:0] step = '0;
   logic        out_ready = 1'b1;

   logic        busy, done, out_valid;
   logic [10:0] rd_addr;
   logic [31:0] rd_data, pix0, pix1;
   logic [7:0]  frac;

   logic        busy2, done2, out_valid2;
   logic [10:0] rd_addr2;
   logic [31:0] rd_data2, rd_stage2, pix0_2, pix1_2;
   logic [7:0]  frac2;

   logic [31:0] mem [2048];

   typedef struct {
      logic [31:0] p0;
      logic [31:0] p1;
      logic [7:0]  fr;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int c0 = 0;
   int xfer_cnt, done_cnt, done_cyc, first_cyc, first_cyc2, last_rise;
   bit in_pass = 1'b0;
   bit check_period = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_valid2 = 1'b0;

   interpolation_line_reader #(.RD_LATENCY(1)) dut (
      .rd_clk(clk), .rd_rst(rst), .start(start), .src_len(src_len), .dst_len(dst_len),
      .step(step), .busy(busy), .done(done), .ram_rd_addr(rd_addr), .ram_rd_data(rd_data),
      .pix0(pix0), .pix1(pix1), .frac(frac), .out_valid(out_valid), .out_ready(out_ready)
   );

   interpolation_line_reader #(.RD_LATENCY(2)) dut2 (
      .rd_clk(clk), .rd_rst(rst), .start(start), .src_len(src_len), .dst_len(dst_len),
      .step(step), .busy(busy2), .done(done2), .ram_rd_addr(rd_addr2), .ram_rd_data(rd_data2),
      .pix0(pix0_2), .pix1(pix1_2), .frac(frac2), .out_valid(out_valid2), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // RAM models: one registered read stage, and a second with an output register.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      rd_data   <= mem[rd_addr];
      rd_stage2 <= mem[rd_addr2];
      rd_data2  <= rd_stage2;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Every presented pixel is compared against the scoreboard head until it is accepted.
   always @(negedge clk) begin
      if (!rst && in_pass) begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc - c0 + 1;
         end
         if (out_valid && !prev_valid) begin
            if (first_cyc < 0) first_cyc = cyc - c0 + 1;
            else if (check_period) checkOutput("period", cyc - last_rise, 4);
            last_rise = cyc;
         end
         if (out_valid2 && !prev_valid2 && first_cyc2 < 0) first_cyc2 = cyc - c0 + 1;
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("extra_valid", 1, 0);
            end else begin
               checkOutput("pix0", pix0, sb[0].p0);
               checkOutput("pix1", pix1, sb[0].p1);
               checkOutput("frac", {24'h0, frac}, {24'h0, sb[0].fr});
               if (out_ready) begin
                  void'(sb.pop_front());
                  xfer_cnt++;
               end
            end
         end
      end
      prev_valid  = out_valid;
      prev_valid2 = out_valid2;
   end

   task automatic applyStimulus(input int src, input int dst, input int st, input bit stall);
      longint p;
      int     i, i0, i1;
      bit     stalled = 1'b0;
      bit     finished = 1'b0;
      exp_t   e;
      if (src > 0) begin
         for (int k = 0; k < dst; k++) begin
            p = longint'(k) * longint'(st);
            if (p > 64'hFFFFF) p = 64'hFFFFF;
            i    = int'(p >> 8);
            i0   = (i > src - 1) ? src - 1 : i;
            i1   = (i + 1 > src - 1) ? src - 1 : i + 1;
            e.p0 = mem[i0];
            e.p1 = mem[i1];
            e.fr = p[7:0];
            sb.push_back(e);
         end
      end
      src_len      = 11'(src);
      dst_len      = 11'(dst);
      step         = 19'(st);
      first_cyc    = -1;
      first_cyc2   = -1;
      done_cnt     = 0;
      done_cyc     = -1;
      xfer_cnt     = 0;
      check_period = !stall;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c0      = cyc;
      in_pass = 1'b1;
      if (src > 0 && dst > 0) checkOutput("busy_on_start", busy, 1);
      for (int n = 0; n < 1000 && !finished; n++) begin
         if (stall && !stalled && out_valid && xfer_cnt == 2) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
            stalled = 1'b1;
         end
         @(posedge clk);
         #1;
         finished = (done_cnt > 0) && !busy2 && !busy;
      end
      checkOutput("pass_timeout", finished, 1);
      repeat (3) @(posedge clk);
      #1;
      in_pass = 1'b0;
      checkOutput("done_count", done_cnt, 1);
      checkOutput("busy_after", busy, 0);
      checkOutput("sb_empty", sb.size(), 0);
      if (src > 0 && dst > 0) begin
         checkOutput("xfer_count", xfer_cnt, dst);
         checkOutput("first_valid_lat1", first_cyc, 4);
         checkOutput("first_valid_lat2", first_cyc2, 5);
      end else begin
         checkOutput("zero_done_cycle", done_cyc, 1);
         checkOutput("zero_no_valid", first_cyc, -1);
      end
      sb.delete();
   endtask

   initial begin
      for (int k = 0; k < 2048; k++) mem[k] = 32'h10 + k;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_addr", rd_addr, 0);
      checkOutput("rst_pix0", pix0, 0);
      checkOutput("rst_frac", frac, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] identity pass");
      applyStimulus(4, 4, 'h100, 1'b0);
      $display("[TB] 2x upscale pass");
      applyStimulus(4, 8, 'h080, 1'b0);
      $display("[TB] backpressure pass");
      applyStimulus(4, 8, 'h080, 1'b1);
      $display("[TB] zero length passes");
      applyStimulus(4, 0, 'h100, 1'b0);
      applyStimulus(0, 4, 'h100, 1'b0);
      $display("[TB] clamp and saturation passes");
      applyStimulus(4, 4, 'h300, 1'b0);
      applyStimulus(6, 6, 'h7FFFF, 1'b0);

      $display("[TB] reset during read wait");
      src_len = 11'd4;
      dst_len = 11'd4;
      step    = 19'h100;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_valid", out_valid, 0);
      checkOutput("midrst_pix0", pix0, 0);
      checkOutput("midrst_addr", rd_addr, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midrst_no_done", done, 0);
      applyStimulus(4, 4, 'h100, 1'b0);

      $display("[TB] random passes");
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 64; k++) mem[k] = $urandom;
         applyStimulus($urandom_range(1, 40), $urandom_range(1, 20), $urandom_range(1, 'h1000), r[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
